pe_drive_tx: RTL and testbench

Clocked initiator for the drive/free channel that feeds the asynchronous round pipeline stages.
- Accepts 64-bit words from a synchronous valid/ready source and buffers them in a small FIFO.
- Presents each word on o_data with an o_drive pulse, then waits for the downstream stage's free level to return before issuing the next word.
- Sits at the synchronous-to-asynchronous boundary in front of the first round stage.

---
 rtl/pe_tx_pkg.sv | 21 ++
 rtl/pe_tx_fifo.sv | 48 ++++
 rtl/pe_drive_tx.sv | 142 ++++++++++++++
 tb/tb_pe_drive_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_tx_pkg.sv
// Shared types and constants for the pe_drive_tx initiator and its input FIFO.
package pe_tx_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRIVE     = 2'd1,
    WAIT_FREE = 2'd2
  } tx_state_e;

  localparam int DATA_W_DEF     = 64;
  localparam int CNT_W          = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // Index width for a power-of-two FIFO; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int PTR_W = ptr_w(FIFO_DEPTH_DEF);

endpackage

// File: rtl/pe_tx_fifo.sv
// Synchronous FIFO with registered pointers; full/empty decode straight from the pointers.
module pe_tx_fifo
  import pe_tx_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: the storage array has no reset; only the pointers define validity, so flushing is free.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/pe_drive_tx.sv
// Drive/free channel initiator: buffers words and issues one o_drive pulse per free handshake.
// Optional wait timeout is built only when PE_DRIVE_TX_TIMEOUT_EN is defined.
module pe_drive_tx
  import pe_tx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int DRIVE_W     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              o_drive,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_free,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_cnt,
  output logic              err_timeout
);

  localparam int PW_W = $clog2(DRIVE_W + 1);

  tx_state_e         state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              free_s, free_prev, free_rise;
  logic [DATA_W-1:0] fifo_rdata, data_q;
  logic              fifo_full, fifo_empty;
  logic              pop, complete, timeout;
  logic [PW_W-1:0]   pulse_cnt;
  logic              drive_q, done_l;
  logic [CNT_W-1:0]  sent_q;

  pe_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .pop   (pop),
    .wdata (s_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign free_s    = sync_q[SYNC_STAGES-1];
  assign free_rise = free_s & ~free_prev;

  // NOTE: every output of this block gets a default first, so no branch can infer a latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && free_s) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (timeout)                      state_d = IDLE;
        else if (pulse_cnt == PW_W'(1))   state_d = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (free_rise || done_l) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (timeout) begin
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here, so each flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      free_prev <= 1'b1;
      data_q    <= '0;
      drive_q   <= 1'b0;
      pulse_cnt <= '0;
      done_l    <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_free};
      free_prev <= free_s;
      if (pop) begin
        data_q    <= fifo_rdata;
        drive_q   <= 1'b1;
        pulse_cnt <= PW_W'(DRIVE_W);
      end else if (state_q == DRIVE) begin
        pulse_cnt <= pulse_cnt - PW_W'(1);
        if (state_d != DRIVE) drive_q <= 1'b0;
      end
      // A free edge that lands inside the pulse is remembered for the wait phase.
      if (state_d == IDLE)                      done_l <= 1'b0;
      else if (state_q == DRIVE && free_rise)   done_l <= 1'b1;
      if (complete) sent_q <= sent_q + CNT_W'(1);
    end
  end

`ifdef PE_DRIVE_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pop)                   to_cnt <= '0;
      else if (state_q != IDLE)  to_cnt <= to_cnt + TO_W'(1);
      if (timeout && !complete)  err_q  <= 1'b1;
    end
  end

  assign timeout     = (state_q != IDLE) && (to_cnt == TO_W'(TIMEOUT - 1));
  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign s_ready  = ~fifo_full;
  assign o_drive  = drive_q;
  assign o_data   = data_q;
  assign busy     = (state_q != IDLE);
  assign sent_cnt = sent_q;

endmodule

// File: tb/tb_pe_drive_tx.sv
// Scoreboard bench for pe_drive_tx: stimulus queues expected words, a monitor checks each drive pulse.
module tb_pe_drive_tx;

  localparam int DATA_W  = 64;
  // Pulse widened so a free-low that meets the synchronizer minimum can start and end inside it.
  localparam int DRIVE_W = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              o_drive;
  logic [DATA_W-1:0] o_data;
  logic              i_free;
  logic              busy;
  logic [15:0]       sent_cnt;
  logic              err_timeout;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [15:0]       exp_sent = '0;

  pe_drive_tx #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (4),
    .DRIVE_W     (DRIVE_W),
    .SYNC_STAGES (2),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .o_drive     (o_drive),
    .o_data      (o_data),
    .i_free      (i_free),
    .busy        (busy),
    .sent_cnt    (sent_cnt),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (busy && n < max) begin
      step();
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic wait_busy(input string name, input int max);
    int n = 0;
    while (!busy && n < max) begin
      step();
      n++;
    end
    check(name, busy, 1'b1);
  endtask

  // Monitor: every rising o_drive must carry the next expected word, last DRIVE_W cycles, and hold data.
  initial begin
    logic              drive_prev = 1'b0;
    int                width      = 0;
    logic [DATA_W-1:0] cur        = '0;
    forever begin
      @(negedge clk);
      if (o_drive && !drive_prev) begin
        width = 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_drive: o_data 0x%0h with no word expected", o_data);
        end else begin
          cur = exp_q.pop_front();
          check("drive_data", o_data, cur);
        end
      end else if (o_drive) begin
        width++;
      end else if (drive_prev) begin
        check("drive_width", 64'(width), 64'(DRIVE_W));
        check("data_hold", o_data, cur);
      end
      drive_prev = o_drive;
    end
  end

  initial begin
    logic [DATA_W-1:0] words [6];
    words[0] = 64'h0123_4567_89AB_CDEF;
    words[1] = 64'hA5A5_0000_FFFF_5A5A;
    words[2] = 64'h0000_0000_0000_0001;
    words[3] = 64'h8000_0000_0000_0000;
    words[4] = 64'hDEAD_BEEF_CAFE_F00D;
    words[5] = 64'hFFFF_FFFF_FFFF_FFFF;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; i_free = 1'b1;
    step(3);
    rst = 1'b0;
    check("rst_drive", o_drive, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    check("rst_sent", sent_cnt, 16'd0);
    check("rst_data", o_data, 64'd0);
    check("rst_err", err_timeout, 1'b0);

    // Single word, one-cycle latency from push to drive.
    s_valid = 1'b1; s_data = words[0]; exp_q.push_back(words[0]);
    step();
    s_valid = 1'b0;
    check("t1_not_yet", o_drive, 1'b0);
    step();
    check("t1_drive", o_drive, 1'b1);
    check("t1_busy", busy, 1'b1);
    check("t1_data", o_data, words[0]);
    step(DRIVE_W);
    check("t1_drive_end", o_drive, 1'b0);
    check("t1_waiting", busy, 1'b1);
    i_free = 1'b0; step(4); i_free = 1'b1;
    wait_idle("t1_idle", 20);
    exp_sent++;
    check("t1_sent", sent_cnt, exp_sent);

    // Fill the FIFO while the stage is busy; fifth word must be refused.
    i_free = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = words[i+1];
      check("t2_ready", s_ready, 1'b1);
      exp_q.push_back(words[i+1]);
      step();
    end
    s_data = words[5];
    check("t2_full", s_ready, 1'b0);
    step();
    s_valid = 1'b0;
    check("t2_no_drive", busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i_free = 1'b1;
      wait_busy("t2_start", 10);
      i_free = 1'b0; step(4); i_free = 1'b1;
      wait_idle("t2_idle", 20);
      check("t2_gap", o_drive, 1'b0);
      exp_sent++;
    end
    check("t2_sent", sent_cnt, exp_sent);
    check("t2_ready_after", s_ready, 1'b1);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Free edge arrives inside the drive pulse: completes one cycle after the pulse.
    step(2);
    s_valid = 1'b1; s_data = words[3]; exp_q.push_back(words[3]); i_free = 1'b0;
    step();
    s_valid = 1'b0;
    step();
    check("t3_drive", o_drive, 1'b1);
    step();
    i_free = 1'b1;
    step(2);
    check("t3_drive_hi", o_drive, 1'b1);
    step();
    check("t3_drive_lo", o_drive, 1'b0);
    check("t3_wait", busy, 1'b1);
    step();
    exp_sent++;
    check("t3_done", busy, 1'b0);
    check("t3_sent", sent_cnt, exp_sent);

    // Reset while waiting for free with two words queued.
    step(2);
    s_valid = 1'b1; s_data = words[4]; exp_q.push_back(words[4]);
    step();
    s_data = words[5]; exp_q.push_back(words[5]);
    step();
    s_data = words[1]; exp_q.push_back(words[1]); i_free = 1'b0;
    step();
    s_valid = 1'b0;
    step(3);
    check("t4_in_wait", busy, 1'b1);
    check("t4_drive_lo", o_drive, 1'b0);
    step();
    rst = 1'b1; i_free = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    exp_sent = '0;
    check("t4_drive", o_drive, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_ready", s_ready, 1'b1);
    check("t4_sent", sent_cnt, exp_sent);
    step(20);
    check("t4_stay_idle", busy, 1'b0);

`ifdef PE_DRIVE_TX_TIMEOUT_EN
    // Stage never frees: word dropped after TIMEOUT cycles, next word goes once free returns.
    s_valid = 1'b1; s_data = words[2]; exp_q.push_back(words[2]);
    step();
    s_data = words[0]; exp_q.push_back(words[0]);
    step();
    s_valid = 1'b0; i_free = 1'b0;
    step(TIMEOUT - 1);
    check("t5_pre_err", err_timeout, 1'b0);
    check("t5_pre_busy", busy, 1'b1);
    step();
    check("t5_err", err_timeout, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_sent", sent_cnt, exp_sent);
    step(3);
    check("t5_hold", busy, 1'b0);
    i_free = 1'b1;
    wait_busy("t5_next", 10);
    i_free = 1'b0; step(4); i_free = 1'b1;
    wait_idle("t5_idle", 20);
    exp_sent++;
    check("t5_sent2", sent_cnt, exp_sent);
    check("t5_sticky", err_timeout, 1'b1);
`else
    check("no_timeout_err", err_timeout, 1'b0);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
